demux_4: RTL and testbench



---
 rtl/demux_4_if.sv | 34 +++
 rtl/demux_4.sv | 100 ++++++++++
 tb/tb_demux_4.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_4_if.sv
// Producer/consumer bundle for the 1-to-4 word demultiplexer.
// The producer side carries one word plus a destination code; the consumer
// side carries four independent valid/ready/data lanes.
interface demux_4_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_control;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data [0:3];

  // Demultiplexer side: receives the producer stream, drives the lanes.
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_control,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  // Environment side: producer and the four consumers.
  modport master (
    output in_valid,
    output in_data,
    output in_control,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/demux_4.sv
// Registered 1-to-4 word demultiplexer. Each accepted word is steered by its
// destination code into one of four FIFOs that drain independently. Words with
// an unrecognised code are accepted, discarded and counted.
module demux_4 #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  demux_4_if.slave    bus,
  output logic        drop_pulse,
  output logic [15:0] drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic       code_valid;
  logic [1:0] dest;
  logic [3:0] full_w;
  logic       accept;

  logic        drop_pulse_reg;
  logic [15:0] drop_count_reg;

  // Decode the one-hot-ish destination code; anything else is a drop.
  always_comb begin
    code_valid = 1'b1;
    dest       = 2'd0;
    case (bus.in_control)
      3'b000:  dest = 2'd0;
      3'b001:  dest = 2'd1;
      3'b010:  dest = 2'd2;
      3'b100:  dest = 2'd3;
      default: code_valid = 1'b0;
    endcase
  end

  // Ready depends only on the code and FIFO occupancy; drops are always taken.
  // No credit is given for a same-cycle pop, so out_ready never reaches here.
  assign bus.in_ready = nRST && (!code_valid || !full_w[dest]);
  assign accept       = bus.in_valid && bus.in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
      logic [31:0]   mem_reg [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;
      logic          push;
      logic          pop;

      assign push = accept && code_valid && (dest == 2'(gi));
      // An empty FIFO has no head, so out_ready is ignored there.
      assign pop  = (count_reg != '0) && bus.out_ready[gi];

      assign full_w[gi]        = (count_reg == FULL_CNT);
      assign bus.out_valid[gi] = (count_reg != '0);
      assign bus.out_data[gi]  = mem_reg[rd_ptr_reg];

      // FIFO storage, pointers and occupancy; reset clears contents too.
      always_ff @(posedge CLK) begin
        if (!nRST) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          for (int k = 0; k < DEPTH; k++) begin
            mem_reg[k] <= '0;
          end
        end else begin
          if (push) begin
            mem_reg[wr_ptr_reg] <= bus.in_data;
            wr_ptr_reg          <= wr_ptr_reg + PW'(1);
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          count_reg <= count_reg + CW'(push) - CW'(pop);
        end
      end
    end
  endgenerate

  // Drop flag for the cycle after a discarded word, plus a saturating tally.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      drop_pulse_reg <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      drop_pulse_reg <= accept && !code_valid;
      if (accept && !code_valid && (drop_count_reg != 16'hFFFF)) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  assign drop_pulse = drop_pulse_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_demux_4.sv
// Directed bench for demux_4 (DEPTH = 2): routing, backpressure, push/pop
// overlap, drops with saturation, mid-stream reset and pointer wrap.
module tb_demux_4;
  localparam int DEPTH = 2;

  logic        CLK;
  logic        nRST;
  logic        drop_pulse;
  logic [15:0] drop_count;

  demux_4_if bus ();

  demux_4 #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus.slave),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] route_data [4];
  logic [2:0]  route_code [4];
  logic [31:0] exp_q [$];
  int          sent;
  int          rcvd;
  logic        push;
  logic        pop;

  initial begin
    route_data[0] = 32'hAAAA0000; route_code[0] = 3'b000;
    route_data[1] = 32'hBBBB0001; route_code[1] = 3'b001;
    route_data[2] = 32'hCCCC0002; route_code[2] = 3'b010;
    route_data[3] = 32'hDDDD0003; route_code[3] = 3'b100;

    nRST           = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_control = 3'b000;
    bus.out_ready  = 4'b0000;
    repeat (2) tick();

    // Reset state
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 4'b0000);
    chk("rst_drop_pulse", drop_pulse, 1'b0);
    chk("rst_drop_count", drop_count, 16'd0);
    for (int i = 0; i < 4; i++) chk("rst_out_data", bus.out_data[i], 32'd0);
    nRST = 1'b1;
    #1;
    chk("post_rst_ready", bus.in_ready, 1'b1);

    // Routing: each word lands only on its own port, one cycle after accept
    bus.out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid   = 1'b1;
      bus.in_control = route_code[k];
      bus.in_data    = route_data[k];
      #1;
      chk("route_ready", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("route_valid", bus.out_valid, 32'd1 << k);
      chk("route_data", bus.out_data[k], route_data[k]);
      tick();
      chk("route_drained", bus.out_valid, 4'b0000);
    end

    // Backpressure on FIFO 1
    bus.out_ready  = 4'b0000;
    bus.in_valid   = 1'b1;
    bus.in_control = 3'b001;
    bus.in_data    = 32'h11110001;
    #1; chk("bp_ready_w1", bus.in_ready, 1'b1);
    tick();
    bus.in_data = 32'h11110002;
    #1; chk("bp_ready_w2", bus.in_ready, 1'b1);
    tick();
    bus.in_data = 32'h11110003;
    #1; chk("bp_ready_full", bus.in_ready, 1'b0);
    tick();
    chk("bp_head_w1", bus.out_data[1], 32'h11110001);
    bus.out_ready = 4'b0010;
    #1; chk("bp_ready_no_bypass", bus.in_ready, 1'b0);
    tick();
    bus.out_ready = 4'b0000;
    #1;
    chk("bp_ready_back", bus.in_ready, 1'b1);
    chk("bp_head_w2", bus.out_data[1], 32'h11110002);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0010;
    #1; chk("bp_out_w2", bus.out_data[1], 32'h11110002);
    tick();
    chk("bp_out_w3", bus.out_data[1], 32'h11110003);
    chk("bp_valid_w3", bus.out_valid[1], 1'b1);
    tick();
    chk("bp_empty", bus.out_valid, 4'b0000);

    // Simultaneous push/pop on FIFO 2 holding one word
    bus.out_ready  = 4'b0000;
    bus.in_valid   = 1'b1;
    bus.in_control = 3'b010;
    bus.in_data    = 32'h22220001;
    tick();
    chk("pp_valid_pre", bus.out_valid[2], 1'b1);
    bus.in_data   = 32'h22220002;
    bus.out_ready = 4'b0100;
    #1; chk("pp_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    #1;
    chk("pp_valid_mid", bus.out_valid[2], 1'b1);
    chk("pp_new_head", bus.out_data[2], 32'h22220002);
    bus.out_ready = 4'b0100;
    tick();
    chk("pp_single_entry", bus.out_valid[2], 1'b0);

    // Invalid codes back to back
    bus.out_ready = 4'hF;
    chk("drop_pulse_idle", drop_pulse, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.in_control = 3'b011;
    #1; chk("drop_ready_011", bus.in_ready, 1'b1);
    tick(); chk("drop_pulse_1", drop_pulse, 1'b1);
    bus.in_control = 3'b101;
    #1; chk("drop_ready_101", bus.in_ready, 1'b1);
    tick(); chk("drop_pulse_2", drop_pulse, 1'b1);
    bus.in_control = 3'b111;
    #1; chk("drop_ready_111", bus.in_ready, 1'b1);
    tick(); chk("drop_pulse_3", drop_pulse, 1'b1);
    chk("drop_count_3", drop_count, 16'd3);
    chk("drop_no_valid", bus.out_valid, 4'b0000);
    bus.in_valid = 1'b0;
    tick();
    chk("drop_pulse_end", drop_pulse, 1'b0);

    // Saturation: run the tally up to 0xFFFE, then three more drops
    bus.in_valid   = 1'b1;
    bus.in_control = 3'b110;
    repeat (65531) tick();
    chk("sat_fffe", drop_count, 16'hFFFE);
    repeat (3) tick();
    chk("sat_ffff", drop_count, 16'hFFFF);
    chk("sat_pulse", drop_pulse, 1'b1);
    bus.in_valid = 1'b0;
    tick();

    // Reset in the middle of traffic
    bus.out_ready  = 4'b0000;
    bus.in_valid   = 1'b1;
    bus.in_control = 3'b000;
    bus.in_data    = 32'h33330000;
    tick();
    bus.in_control = 3'b100;
    bus.in_data    = 32'h33330003;
    tick();
    chk("mr_filled", bus.out_valid, 4'b1001);
    nRST           = 1'b0;
    bus.in_control = 3'b000;
    bus.in_data    = 32'h33339999;
    #1; chk("mr_ready_low", bus.in_ready, 1'b0);
    tick();
    nRST         = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mr_out_valid", bus.out_valid, 4'b0000);
    chk("mr_drop_count", drop_count, 16'd0);
    chk("mr_drop_pulse", drop_pulse, 1'b0);
    for (int i = 0; i < 4; i++) chk("mr_out_data", bus.out_data[i], 32'd0);

    // Wrap-around on FIFO 3 with random consumer stalls
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
      if (sent < 10) begin
        bus.in_valid   = 1'b1;
        bus.in_control = 3'b100;
        bus.in_data    = 32'h50000000 + 32'(sent);
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = {(($urandom_range(0, 1) == 1) || (sent >= 10)), 3'b000};
      #1;
      chk("wrap_ready", bus.in_ready, exp_q.size() < DEPTH);
      chk("wrap_valid", bus.out_valid[3], exp_q.size() != 0);
      push = bus.in_valid && bus.in_ready;
      pop  = bus.out_valid[3] && bus.out_ready[3];
      if (pop && exp_q.size() != 0) begin
        chk("wrap_data", bus.out_data[3], exp_q[0]);
        void'(exp_q.pop_front());
        rcvd++;
      end
      if (push) begin
        exp_q.push_back(bus.in_data);
        sent++;
      end
      tick();
    end
    chk("wrap_received", rcvd, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
